// File: rtl/wb_host_master.sv
// wb_host_master: Wishbone classic single-transfer initiator.
// Commands arrive on a valid/ready stream and are buffered in a small FIFO.
// They are issued one at a time on the bus, each guarded by an ack timeout.
// Each command yields exactly one response, in command order.
module wb_host_master #(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  // response stream
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // wishbone initiator
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wdata,
  input  logic [31:0] wb_rdata,
  input  logic        wb_ack,
  // status
  output logic        busy,
  output logic [15:0] timeout_count
);

  localparam int unsigned        PTR_W        = $clog2(CMD_DEPTH);
  localparam logic [PTR_W:0]     DEPTH_CNT    = (PTR_W+1)'(CMD_DEPTH);
  localparam logic [PTR_W:0]     CNT_ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE      = PTR_W'(1);
  localparam logic [15:0]        TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             fifo_mem [CMD_DEPTH];
  cmd_t             cmd_in;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push;
  logic             pop;

  // FSM and registered outputs
  state_t      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] timeout_count_q, timeout_count_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;

  assign cmd_in = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  assign head   = fifo_mem[rd_ptr_q];

  // cmd_ready_q always mirrors "not full", so this never overflows.
  assign push = cmd_valid && cmd_ready_q;
  // The head is taken only when the FSM is ready to start a new transfer.
  assign pop  = (state_q == ST_IDLE) && (count_q != '0);

  // Store the accepted command in the slot under the write pointer.
  // NOTE: the storage array has no reset; emptiness is defined by count_q,
  // so stale entries are never read and resetting them would only cost flops.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= cmd_in;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap because depth is 2^n.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM: IDLE -> REQ (wait for ack or timeout) -> RSP (handshake)
  // ---------------------------------------------------------------------------
  // Next-state and next-output logic for the bus, response and status flops.
  // NOTE: every variable gets a hold value first, so branches that do not
  // assign it keep the old value instead of inferring a latch.
  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    cyc_d           = cyc_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_err_d       = rsp_err_q;
    timeout_count_d = timeout_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          we_d    = head.we;
          addr_d  = head.addr;
          wdata_d = head.wdata;
          cyc_d   = 1'b1;
          wait_d  = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        // An ack on the same edge as the limit wins over the timeout.
        if (wb_ack) begin
          cyc_d       = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : wb_rdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else if (wait_q == TIMEOUT_LAST) begin
          cyc_d       = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          if (timeout_count_q != 16'hFFFF) begin
            timeout_count_d = timeout_count_q + 16'd1;
          end
          state_d     = ST_RSP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      ST_RSP: begin
        // The stale repeat ack from the slave lands here and is ignored.
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    cmd_ready_d = (count_d != DEPTH_CNT);
    busy_d      = (count_d != '0) || (state_d != ST_IDLE);
  end

  // State register; reset empties the FIFO and idles the bus immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      state_q         <= ST_IDLE;
      wait_q          <= '0;
      cyc_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      timeout_count_q <= '0;
      cmd_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      state_q         <= state_d;
      wait_q          <= wait_d;
      cyc_q           <= cyc_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
      timeout_count_q <= timeout_count_d;
      cmd_ready_q     <= cmd_ready_d;
      busy_q          <= busy_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign wb_cyc        = cyc_q;
  assign wb_stb        = cyc_q;
  assign wb_we         = we_q;
  assign wb_addr       = addr_q;
  assign wb_wdata      = wdata_q;
  assign busy          = busy_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Testbench for wb_host_master: a registered-ack slave with a stale repeat
// ack, a scoreboard of expected responses, and one task per scenario.
module tb_wb_host_master;

  localparam int unsigned  DEPTH      = 4;
  localparam int unsigned  TMO        = 8;
  localparam logic [31:0]  BASE       = 32'h1000_0000;
  localparam logic [31:0]  BUILD_ADDR = 32'h1000_0010;
  localparam logic [31:0]  BUILD_VAL  = 32'h2026_0226;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic        busy;
  logic [15:0] timeout_count;

  wb_host_master #(
    .CMD_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_wdata     (wb_wdata),
    .wb_rdata     (wb_rdata),
    .wb_ack       (wb_ack),
    .busy         (busy),
    .timeout_count(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Slave model: registered ack after ws extra cycles, repeats once after stb
  // drops because it samples cyc on the edge where the master releases it.
  // ---------------------------------------------------------------------------
  bit [31:0] slv_mem [256];
  bit        ack_en = 1'b1;
  int        ws     = 0;
  int        slv_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_rdata <= 32'h0;
      slv_cnt  <= 0;
    end else if (wb_cyc && wb_stb) begin
      slv_cnt <= slv_cnt + 1;
      if (ack_en && slv_cnt >= ws) begin
        wb_ack <= 1'b1;
        if (wb_we) begin
          if (wb_addr != BUILD_ADDR) slv_mem[wb_addr[9:2]] <= wb_wdata;
          wb_rdata <= 32'h0;
        end else begin
          wb_rdata <= (wb_addr == BUILD_ADDR) ? BUILD_VAL : slv_mem[wb_addr[9:2]];
        end
      end else begin
        wb_ack <= 1'b0;
      end
    end else begin
      wb_ack  <= 1'b0;
      slv_cnt <= 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and monitors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] model_mem [logic [31:0]];
  int          rsp_seen     = 0;
  int          cyc_run      = 0;
  int          last_cyc_len = 0;
  int          cyc_starts   = 0;
  logic        cyc_prev     = 1'b0;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a == BUILD_ADDR) return BUILD_VAL;
    if (model_mem.exists(a)) return model_mem[a];
    return 32'h0;
  endfunction

  // Response handshakes complete on the next posedge; compare them here.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b with empty scoreboard",
                 rsp_rdata, rsp_err);
      end else begin
        e = sb_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err || wb_addr !== e.addr) begin
          errors++;
          $display("FAIL rsp_compare: got rdata=%h err=%b addr=%h, expected rdata=%h err=%b addr=%h",
                   rsp_rdata, rsp_err, wb_addr, e.rdata, e.err, e.addr);
        end
      end
    end
    if (wb_cyc) begin
      cyc_run++;
    end else if (cyc_run != 0) begin
      last_cyc_len = cyc_run;
      cyc_run      = 0;
    end
    if (wb_cyc && !cyc_prev) cyc_starts++;
    cyc_prev = wb_cyc;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all leave time at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!cmd_ready && n < 50) begin
      step(1);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    sb_q.push_back('{rdata: exp_rdata, err: exp_err, addr: addr});
    if (we) model_mem[addr] = wdata;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic issue_write(input logic [31:0] addr, input logic [31:0] data);
    push_cmd(1'b1, addr, data, 32'h0, 1'b0);
  endtask

  task automatic issue_read(input logic [31:0] addr);
    push_cmd(1'b0, addr, 32'h0, model_read(addr), 1'b0);
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_seen < target && n < 200) begin
      step(1);
      n++;
    end
    checks++;
    if (rsp_seen < target) begin
      errors++;
      $display("FAIL rsp_wait: got %0d responses, expected %0d", rsp_seen, target);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b1;
    step(3);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we, busy} !== 7'b0 ||
        rsp_rdata !== 32'h0 || wb_addr !== 32'h0 || wb_wdata !== 32'h0 ||
        timeout_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b cyc=%b busy=%b addr=%h tc=%0d, expected all 0",
               cmd_ready, rsp_valid, wb_cyc, busy, wb_addr, timeout_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_read();
    int base = rsp_seen;
    issue_write(BASE, 32'h0000_0009);     // accepted at E0, now E0+1
    checks++;
    if (wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL wr_cyc_e0: cyc=%b, expected 0", wb_cyc);
    end
    step(1);                              // after E1
    checks++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_we !== 1'b1 ||
        wb_addr !== BASE || wb_wdata !== 32'h9) begin
      errors++;
      $display("FAIL wr_bus_e1: cyc=%b stb=%b we=%b addr=%h wdata=%h, expected 1 1 1 %h 9",
               wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, BASE);
    end
    step(2);                              // after E3: registered ack sampled
    checks++;
    if (wb_cyc !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_rsp_e3: cyc=%b valid=%b err=%b rdata=%h, expected 0 1 0 0",
               wb_cyc, rsp_valid, rsp_err, rsp_rdata);
    end
    wait_rsp(base + 1);
    checks++;
    if (last_cyc_len != 2 || wb_we !== 1'b1 || wb_addr !== BASE) begin
      errors++;
      $display("FAIL wr_cyc_len: len=%0d we=%b addr=%h, expected 2 1 %h",
               last_cyc_len, wb_we, wb_addr, BASE);
    end
    issue_read(BASE);
    wait_rsp(base + 2);
    checks++;
    if (last_cyc_len != 2 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL rd_cyc_len: len=%0d we=%b, expected 2 0", last_cyc_len, wb_we);
    end
  endtask

  task automatic test_build_info();
    int base = rsp_seen;
    issue_read(BUILD_ADDR);
    wait_rsp(base + 1);
    step(6);
    checks++;
    if (rsp_seen != base + 1 || sb_q.size() != 0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL build_single_rsp: responses=%0d pending=%0d valid=%b, expected 1 0 0",
               rsp_seen - base, sb_q.size(), rsp_valid);
    end
  endtask

  task automatic test_timeout();
    int base = rsp_seen;
    ack_en = 1'b0;
    push_cmd(1'b0, BASE + 32'h8, 32'h0, 32'h0, 1'b1);
    wait_rsp(base + 1);
    checks++;
    if (last_cyc_len != TMO || timeout_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: cyc_len=%0d tc=%0d busy=%b, expected %0d 1 0",
               last_cyc_len, timeout_count, busy, TMO);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_ack_at_limit();
    int base = rsp_seen;
    ws = 6;                               // ack sampled on the limit edge
    issue_read(BASE);
    wait_rsp(base + 1);
    checks++;
    if (last_cyc_len != TMO || timeout_count !== 16'd1) begin
      errors++;
      $display("FAIL ack_wins: cyc_len=%0d tc=%0d, expected %0d 1", last_cyc_len, timeout_count, TMO);
    end
    ws = 7;                               // ack one edge too late
    push_cmd(1'b0, BASE, 32'h0, 32'h0, 1'b1);
    wait_rsp(base + 2);
    step(3);
    checks++;
    if (last_cyc_len != TMO || timeout_count !== 16'd2 || rsp_seen != base + 2) begin
      errors++;
      $display("FAIL late_ack: cyc_len=%0d tc=%0d rsps=%0d, expected %0d 2 2",
               last_cyc_len, timeout_count, rsp_seen - base, TMO);
    end
    ws = 0;
  endtask

  task automatic test_fifo_full();
    int base     = rsp_seen;
    int accepted = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (accepted < 6) begin
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = BASE + 32'h20 + 32'(accepted * 4);
        cmd_wdata = 32'hA0 + 32'(accepted);
      end
      if (cmd_valid && cmd_ready) begin
        sb_q.push_back('{rdata: 32'h0, err: 1'b0, addr: cmd_addr});
        model_mem[cmd_addr] = cmd_wdata;
        accepted++;
      end
      step(1);
    end
    checks++;
    if (accepted != 5 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full: accepted=%0d cmd_ready=%b busy=%b, expected 5 0 1",
               accepted, cmd_ready, busy);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp(base + 5);
    step(4);
    checks++;
    if (rsp_seen != base + 5 || sb_q.size() != 0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_drain: responses=%0d pending=%0d cmd_ready=%b, expected 5 0 1",
               rsp_seen - base, sb_q.size(), cmd_ready);
    end
  endtask

  task automatic test_backpressure();
    int          base = rsp_seen;
    int          starts;
    int          n = 0;
    logic [31:0] held;
    rsp_ready = 1'b0;
    issue_read(BASE);
    issue_read(BUILD_ADDR);
    while (!rsp_valid && n < 50) begin
      step(1);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== model_read(BASE)) begin
      errors++;
      $display("FAIL bp_first: valid=%b rdata=%h, expected 1 %h", rsp_valid, rsp_rdata, model_read(BASE));
    end
    held   = rsp_rdata;
    starts = cyc_starts;
    for (int c = 0; c < 10; c++) begin
      step(1);
      checks++;
      if (wb_cyc !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== held) begin
        errors++;
        $display("FAIL bp_hold_%0d: cyc=%b valid=%b rdata=%h, expected 0 1 %h",
                 c, wb_cyc, rsp_valid, rsp_rdata, held);
      end
    end
    checks++;
    if (cyc_starts != starts) begin
      errors++;
      $display("FAIL bp_no_cyc: cyc starts=%0d, expected %0d", cyc_starts, starts);
    end
    rsp_ready = 1'b1;
    wait_rsp(base + 2);
  endtask

  task automatic test_reset_mid();
    int base;
    int starts;
    ack_en    = 1'b0;
    rsp_ready = 1'b1;
    issue_read(BASE);
    issue_read(BASE + 32'h4);
    issue_read(BASE + 32'h8);
    checks++;
    if (wb_cyc !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: cyc=%b busy=%b, expected 1 1", wb_cyc, busy);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        timeout_count !== 16'h0) begin
      errors++;
      $display("FAIL rst_async: cyc=%b stb=%b valid=%b busy=%b tc=%0d, expected all 0",
               wb_cyc, wb_stb, rsp_valid, busy, timeout_count);
    end
    sb_q.delete();
    step(2);
    @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    starts = cyc_starts;
    base   = rsp_seen;
    step(20);
    checks++;
    if (cyc_starts != starts || rsp_seen != base || busy !== 1'b0 || wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet: cyc starts=%0d rsps=%0d busy=%b, expected %0d %0d 0",
               cyc_starts, rsp_seen, busy, starts, base);
    end
    issue_read(BASE);
    wait_rsp(base + 1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_build_info();
    test_timeout();
    test_ack_at_limit();
    test_fifo_full();
    test_backpressure();
    test_reset_mid();
    step(4);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected responses never arrived", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
